// File: rtl/led_shifter_pkg.sv
// Shared types and defaults for the LED shifter sequencing logic.
package led_shifter_pkg;

  typedef enum logic [1:0] {
    ST_LIVE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_PAGES        = 2;
  localparam int unsigned DEFAULT_DWELL_CYCLES = 50_000_000;
  localparam int unsigned DEFAULT_BLANK_CYCLES = 25_000_000;
  localparam int unsigned DEFAULT_QDEPTH       = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Page index width; a single page still needs one bit.
  function automatic int unsigned page_w(input int unsigned pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// 1-bit wide synchronous FIFO holding pending shift requests (show-ahead output).
module cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    async_nreset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    din,
  output logic                    dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_q];

  // Next-state for storage, pointers and occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/history_display_sequencer.sv
// Sequences live shifts, timed history-page display and replay of shifts queued while in history mode.
module history_display_sequencer
  import led_shifter_pkg::*;
#(
  parameter int unsigned PAGES        = DEFAULT_PAGES,
  parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  parameter int unsigned QDEPTH       = DEFAULT_QDEPTH
) (
  input  logic                        clk,
  input  logic                        async_nreset,
  input  logic                        button0_re,
  input  logic                        button1_re,
  input  logic                        show_history_deb,
  output logic                        shift_en,
  output logic                        shift_bit,
  output logic                        display_hist,
  output logic [page_w(PAGES)-1:0]    page_sel,
  output logic                        blank,
  output logic [$clog2(QDEPTH):0]     q_count,
  output logic                        overflow
);

  localparam int unsigned PW = page_w(PAGES);
  localparam int unsigned CW = $clog2(max_u(DWELL_CYCLES, BLANK_CYCLES));

  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] page_q, page_d;
  logic          shift_en_q, shift_en_d;
  logic          shift_bit_q, shift_bit_d;
  logic          display_hist_q, display_hist_d;
  logic          blank_q, blank_d;
  logic          overflow_q, overflow_d;

  logic req, req_bit;
  logic push_req, fifo_push, fifo_pop;
  logic fifo_dout, fifo_full, fifo_empty;

  // button0 has priority: a double press is a single request for a 0.
  assign req     = button0_re | button1_re;
  assign req_bit = ~button0_re;

  cmd_fifo #(
    .DEPTH (QDEPTH)
  ) u_cmd_fifo (
    .clk          (clk),
    .async_nreset (async_nreset),
    .push         (fifo_push),
    .pop          (fifo_pop),
    .din          (req_bit),
    .dout         (fifo_dout),
    .count        (q_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // Mode sequencing, dwell/page counting and request routing; all outputs take their next value here.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    page_d         = page_q;
    shift_en_d     = 1'b0;
    shift_bit_d    = 1'b0;
    display_hist_d = display_hist_q;
    blank_d        = blank_q;
    push_req       = 1'b0;
    fifo_pop       = 1'b0;

    case (state_q)
      ST_LIVE: begin
        if (req) begin
          if (fifo_empty) begin
            shift_en_d  = 1'b1;
            shift_bit_d = req_bit;
          end else begin
            push_req = 1'b1;
          end
        end
        if (show_history_deb) begin
          state_d        = ST_SHOW;
          cnt_d          = '0;
          page_d         = '0;
          display_hist_d = 1'b1;
          blank_d        = 1'b0;
        end
      end

      ST_SHOW, ST_BLANK: begin
        push_req = req;
        if (!show_history_deb) begin
          // A request arriving with the release still counts as queued, so it forces a drain.
          state_d        = (!fifo_empty || req) ? ST_DRAIN : ST_LIVE;
          cnt_d          = '0;
          page_d         = '0;
          display_hist_d = 1'b0;
          blank_d        = 1'b0;
        end else if (state_q == ST_SHOW) begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (page_q == PAGE_LAST) begin
              state_d = ST_BLANK;
              blank_d = 1'b1;
            end else begin
              page_d = page_q + PW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            page_d  = '0;
            blank_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_DRAIN: begin
        push_req = req;
        if (show_history_deb) begin
          state_d        = ST_SHOW;
          cnt_d          = '0;
          page_d         = '0;
          display_hist_d = 1'b1;
          blank_d        = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_en_d  = 1'b1;
          shift_bit_d = fifo_dout;
        end else if (!req) begin
          state_d = ST_LIVE;
        end
      end

      default: state_d = ST_LIVE;
    endcase

    fifo_push  = push_req & (~fifo_full | fifo_pop);
    overflow_d = overflow_q | (push_req & fifo_full & ~fifo_pop);
    // LIVE is only ever entered with an empty queue, which is when the drop flag is retired.
    if ((state_d == ST_LIVE) && (state_q != ST_LIVE)) begin
      overflow_d = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q        <= ST_LIVE;
      cnt_q          <= '0;
      page_q         <= '0;
      shift_en_q     <= 1'b0;
      shift_bit_q    <= 1'b0;
      display_hist_q <= 1'b0;
      blank_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      page_q         <= page_d;
      shift_en_q     <= shift_en_d;
      shift_bit_q    <= shift_bit_d;
      display_hist_q <= display_hist_d;
      blank_q        <= blank_d;
      overflow_q     <= overflow_d;
    end
  end

  assign shift_en     = shift_en_q;
  assign shift_bit    = shift_bit_q;
  assign display_hist = display_hist_q;
  assign page_sel     = page_q;
  assign blank        = blank_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_history_display_sequencer.sv
// Bench for history_display_sequencer: directed vector table, hand sequences, random run against a reference model.
module tb_history_display_sequencer;

  localparam int unsigned PAGES  = 2;
  localparam int unsigned DWELL  = 4;
  localparam int unsigned BLANKC = 2;
  localparam int unsigned QD     = 2;
  localparam int unsigned PERIOD = PAGES * DWELL + BLANKC;

  localparam int M_LIVE  = 0;
  localparam int M_HIST  = 1;
  localparam int M_DRAIN = 2;

  logic       clk = 1'b0;
  logic       async_nreset;
  logic       b0, b1, show;
  logic       shift_en, shift_bit, display_hist, blank, overflow;
  logic [0:0] page_sel;
  logic [1:0] q_count;

  always #5 clk = ~clk;

  history_display_sequencer #(
    .PAGES        (PAGES),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANKC),
    .QDEPTH       (QD)
  ) dut (
    .clk              (clk),
    .async_nreset     (async_nreset),
    .button0_re       (b0),
    .button1_re       (b1),
    .show_history_deb (show),
    .shift_en         (shift_en),
    .shift_bit        (shift_bit),
    .display_hist     (display_hist),
    .page_sel         (page_sel),
    .blank            (blank),
    .q_count          (q_count),
    .overflow         (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode, a time index within the history cycle, and a plain queue.
  int m_mode;
  int m_t;
  bit m_q[$];
  bit m_ov, m_en, m_sb;

  typedef struct {
    bit i0, i1, sh;
    int en, sb, dh, bl, pg, qc, ov;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int en, input int sb, input int dh,
                           input int bl, input int pg, input int qc, input int ov);
    chk({tag, " shift_en"}, int'(shift_en), en);
    if (en != 0) chk({tag, " shift_bit"}, int'(shift_bit), sb);
    chk({tag, " display_hist"}, int'(display_hist), dh);
    chk({tag, " blank"}, int'(blank), bl);
    chk({tag, " page_sel"}, int'(page_sel), pg);
    chk({tag, " q_count"}, int'(q_count), qc);
    chk({tag, " overflow"}, int'(overflow), ov);
  endtask

  task automatic model_reset();
    m_mode = M_LIVE;
    m_t    = 0;
    m_q.delete();
    m_ov   = 1'b0;
    m_en   = 1'b0;
    m_sb   = 1'b0;
  endtask

  task automatic model_push(input bit v);
    if (m_q.size() < QD) m_q.push_back(v);
    else m_ov = 1'b1;
  endtask

  task automatic model_step(input bit i0, input bit i1, input bit sh);
    bit req;
    bit rb;
    req  = i0 | i1;
    rb   = !i0;
    m_en = 1'b0;
    m_sb = 1'b0;
    case (m_mode)
      M_LIVE: begin
        if (req) begin m_en = 1'b1; m_sb = rb; end
        if (sh) begin m_mode = M_HIST; m_t = 0; end
      end
      M_HIST: begin
        if (req) model_push(rb);
        if (!sh) begin
          if (m_q.size() > 0) m_mode = M_DRAIN;
          else begin m_mode = M_LIVE; m_ov = 1'b0; end
        end else begin
          m_t = (m_t + 1) % PERIOD;
        end
      end
      default: begin
        if (sh) begin
          if (req) model_push(rb);
          m_mode = M_HIST;
          m_t    = 0;
        end else begin
          if (m_q.size() > 0) begin m_en = 1'b1; m_sb = m_q.pop_front(); end
          if (req) model_push(rb);
          else if (!m_en) begin m_mode = M_LIVE; m_ov = 1'b0; end
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    int pg;
    int dh;
    int bl;
    dh = (m_mode == M_HIST) ? 1 : 0;
    pg = 0;
    bl = 0;
    if (m_mode == M_HIST) begin
      pg = m_t / DWELL;
      if (pg > PAGES - 1) pg = PAGES - 1;
      bl = (m_t >= PAGES * DWELL) ? 1 : 0;
    end
    check_out(tag, m_en, m_sb, dh, bl, pg, m_q.size(), m_ov);
  endtask

  // One clock: inputs held across the rising edge, outputs sampled 1ns after it.
  task automatic step(input bit i0, input bit i1, input bit sh);
    b0   = i0;
    b1   = i1;
    show = sh;
    @(posedge clk);
    #1;
    model_step(i0, i1, sh);
    b0 = 1'b0;
    b1 = 1'b0;
  endtask

  task automatic do_reset();
    b0 = 1'b0;
    b1 = 1'b0;
    show = 1'b0;
    async_nreset = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    async_nreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sh;
    bit i0, i1;

    // Directed table: live shifts, one full history period, queueing with overflow and drain.
    tbl[0]  = '{0,1,0, 1,1,0,0,0,0,0};
    tbl[1]  = '{0,0,0, 0,0,0,0,0,0,0};
    tbl[2]  = '{1,1,0, 1,0,0,0,0,0,0};
    tbl[3]  = '{0,0,0, 0,0,0,0,0,0,0};
    tbl[4]  = '{1,0,0, 1,0,0,0,0,0,0};
    for (int i = 5; i <= 8; i++)   tbl[i] = '{0,0,1, 0,0,1,0,0,0,0};
    for (int i = 9; i <= 12; i++)  tbl[i] = '{0,0,1, 0,0,1,0,1,0,0};
    for (int i = 13; i <= 14; i++) tbl[i] = '{0,0,1, 0,0,1,1,1,0,0};
    tbl[15] = '{0,0,1, 0,0,1,0,0,0,0};
    tbl[16] = '{0,1,1, 0,0,1,0,0,1,0};
    tbl[17] = '{1,0,1, 0,0,1,0,0,2,0};
    tbl[18] = '{0,1,1, 0,0,1,0,0,2,1};
    tbl[19] = '{0,0,0, 0,0,0,0,0,2,1};
    tbl[20] = '{0,0,0, 1,1,0,0,0,1,1};
    tbl[21] = '{0,0,0, 1,0,0,0,0,0,1};
    tbl[22] = '{0,0,0, 0,0,0,0,0,0,0};

    do_reset();
    check_out("reset", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].i0, tbl[i].i1, tbl[i].sh);
      check_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].sb, tbl[i].dh,
                tbl[i].bl, tbl[i].pg, tbl[i].qc, tbl[i].ov);
    end

    // Push during the first pop of a full queue: order head, second, new; nothing dropped.
    do_reset();
    step(0,0,1); check_out("t4a", 0,0,1,0,0,0,0);
    step(0,1,1); check_out("t4b", 0,0,1,0,0,1,0);
    step(1,0,1); check_out("t4c", 0,0,1,0,0,2,0);
    step(0,0,0); check_out("t4d", 0,0,0,0,0,2,0);
    step(1,0,0); check_out("t4e", 1,1,0,0,0,2,0);
    step(0,0,0); check_out("t4f", 1,0,0,0,0,1,0);
    step(0,0,0); check_out("t4g", 1,0,0,0,0,0,0);
    step(0,0,0); check_out("t4h", 0,0,0,0,0,0,0);
    step(0,1,0); check_out("t4i", 1,1,0,0,0,0,0);

    // History re-entered mid-drain: queue remainder kept, display back to page 0.
    do_reset();
    step(0,0,1);
    step(0,1,1);
    step(1,0,1);
    step(0,0,0); check_out("t5a", 0,0,0,0,0,2,0);
    step(0,0,0); check_out("t5b", 1,1,0,0,0,1,0);
    step(0,0,1); check_out("t5c", 0,0,1,0,0,1,0);
    step(0,0,1); check_out("t5d", 0,0,1,0,0,1,0);

    // Asynchronous reset while blanked with a full queue and overflow set.
    do_reset();
    step(0,0,1);
    step(0,1,1);
    step(1,0,1);
    step(0,1,1); check_out("t6a", 0,0,1,0,0,2,1);
    for (int i = 0; i < 5; i++) step(0,0,1);
    check_out("t6b", 0,0,1,1,1,2,1);
    async_nreset = 1'b0;
    #2;
    model_reset();
    check_out("t6c", 0,0,0,0,0,0,0);
    @(negedge clk);
    async_nreset = 1'b1;
    show = 1'b0;
    step(1,0,0); check_out("t6d", 1,0,0,0,0,0,0);

    // Random run against the reference model.
    do_reset();
    sh = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 11) == 0) sh = !sh;
      i0 = ($urandom_range(0, 3) == 0);
      i1 = ($urandom_range(0, 3) == 0);
      step(i0, i1, sh);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
